x86_length_decoder: RTL and testbench
=====================================

Name: x86_length_decoder

Overview:
- Sequential x86/x86-64 instruction field parser that runs one byte per cycle over a fetch window.
- Walks legacy prefixes, REX, 1/2/3-byte opcode maps, ModRM, SIB, displacement and immediate, then emits one decoded-field record plus the instruction length.
- Sits between the fetch buffer and the execute front end.
- Per-opcode attributes (ModRM present, immediate size) come from an external combinational table through the attr_* ports.

Parameters:
- WIN_BYTES, 16: bytes in the fetch window presented on win_bytes; byte 0 is at bits [0:7].
- MAX_LEN, 15: architectural maximum instruction length in bytes.
- MODE64, 1: 1 means bytes 0x40-0x4F are REX prefixes; 0 means they are opcodes.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  synchronous abort of the current decode.
- win_valid  in  1  fetch window holds valid bytes.
- win_bytes  in  WIN_BYTES*8  window bytes; must stay stable while win_valid=1 and no consume pulse has occurred.
- win_ready  out  1  one-cycle consume pulse.
- win_consume  out  4  bytes consumed; valid while win_ready=1.
- attr_map  out  2  opcode map: 0 = 1-byte, 1 = 0F, 2 = 0F38, 3 = 0F3A.
- attr_opcode  out  8  latched opcode byte.
- attr_opsize16  out  1  0x66 prefix seen.
- attr_rex_w  out  1  REX.W.
- attr_has_modrm  in  1  table response: opcode has a ModRM byte.
- attr_imm_bytes  in  4  table response: immediate size, one of 0, 1, 2, 4 or 8.
- out_valid  out  1  decoded record valid.
- out_ready  in  1  consumer accepts the record.
- out_len  out  4  instruction length.
- out_error  out  2  0 = ok, 1 = too long, 2 = truncated window.
- out_prefix  out  8  [0] lock, [1] repne, [2] rep, [3] opsize, [4] addrsize, [7:5] segment (0 none, 1 ES, 2 CS, 3 SS, 4 DS, 5 FS, 6 GS).
- out_rex_valid  out  1  REX present.
- out_rex  out  4  REX.WRXB.
- out_map  out  2  opcode map.
- out_opcode  out  8  opcode byte.
- out_modrm_valid  out  1  ModRM present.
- out_modrm  out  8  ModRM byte.
- out_sib_valid  out  1  SIB present.
- out_sib  out  8  SIB byte.
- out_disp_bytes  out  3  displacement size: 0, 1 or 4.
- out_disp  out  32  displacement, sign-extended.
- out_imm_bytes  out  4  immediate size.
- out_imm  out  64  immediate, little-endian, zero-extended.

Behaviour:
- Reset (reset=0 at an edge):
  - State goes to IDLE.
  - Every output is 0; cursor, counters and latched fields are cleared.
  - Reset and flush mid-decode behave identically except that flush leaves attr_* values undefined.
  - Neither produces a win_ready pulse.
- Byte fetch: cursor (0..MAX_LEN) indexes win_bytes. Every state that reads a byte first checks, with this priority:
  - cursor==MAX_LEN: set error=1 and go to DONE.
  - otherwise cursor==WIN_BYTES: set error=2 and go to DONE.
- IDLE:
  - If win_valid=1: clear all fields, set cursor=0, go to PREFIX.
- PREFIX (one byte per cycle):
  - Legacy prefix byte (F0, F2, F3, 2E, 36, 3E, 26, 64, 65, 66, 67): set the matching flag. F2 and F3 are mutually exclusive, last one wins. For segment overrides, last one wins. Clear any REX already seen. Increment cursor and stay.
  - 0x4X with MODE64=1: latch REX, increment cursor and stay. A second REX overwrites the first.
  - 0x0F: increment cursor, go to ESC.
  - Any other byte: opcode with map 0; increment cursor, go to ATTR.
- ESC:
  - 0x38 or 0x3A: map 2 or map 3 respectively; increment cursor, go to ESC3.
  - Otherwise: this byte is the opcode with map 1; increment cursor, go to ATTR.
- ESC3: latch the opcode byte, increment cursor, go to ATTR.
- ATTR (no byte consumed): attr_* outputs are driven from latched state. Sample attr_has_modrm and attr_imm_bytes in the same cycle.
  - attr_has_modrm=1: go to MODRM.
  - Else immediate size nonzero: go to IMM.
  - Else: go to DONE.
- MODRM: latch the byte, increment cursor.
  - SIB is needed when mod!=3 and rm==4.
  - Displacement size:
    - mod=1: 1 byte.
    - mod=2: 4 bytes.
    - mod=0 and rm=5: 4 bytes.
    - otherwise: 0.
  - Next state, in order: SIB if needed, then DISP, then IMM, then DONE.
- SIB: latch the byte, increment cursor. If mod=0 and base=5, displacement size is 4. Then go to DISP, IMM or DONE.
- DISP and IMM:
  - One byte per cycle, shifted little-endian into the accumulator.
  - A 1-byte displacement is sign-extended to 32 bits.
  - When the remaining count reaches 0, go to the next state.
- DONE:
  - out_valid=1; out_len=cursor; all fields are held stable.
  - On out_valid && out_ready: win_ready=1 for that cycle with win_consume=out_len, out_valid=0 next cycle, state returns to IDLE.
  - Errored records are handshaken the same way.
  - Back-to-back: IDLE can accept the next window in the cycle after the pulse.
- Latency: out_valid rises N+2 cycles after IDLE samples win_valid, where N is the instruction length (+1 cycle for the ATTR state).

Test Plan:
- Window 90 with attr (0, 0):
  - out_valid rises 3 cycles after win_valid.
  - len=1, map=0, opcode=90, no ModRM.
  - With out_ready=1: win_consume=1.
- 48 89 E5 with attr (1, 0):
  - rex_valid=1, rex=1000, modrm=E5, sib_valid=0, disp_bytes=0.
  - len=3.
- 66 0F 38 00 C1 with attr (1, 0):
  - prefix[3]=1, map=2, opcode=00, modrm=C1.
  - len=5.
- 8B 44 24 08:
  - sib=24, disp=0x00000008, len=4.
- 8B 45 F8:
  - disp=0xFFFFFFF8, disp_bytes=1, len=3.
- 48 C7 05 10 00 00 00 FF FF FF FF with attr (1, 4):
  - disp=0x10, imm=0x00000000FFFFFFFF, len=11.
- Sixteen F0 bytes:
  - error=1, len=15, consume=15.
- 40 66 90:
  - rex_valid=0, prefix[3]=1, len=3.
- flush asserted in the DISP state:
  - No win_ready pulse; out_valid stays 0.
  - The next window decodes cleanly.
- out_ready held 0 for 5 cycles in DONE:
  - Fields are stable throughout.
  - win_ready pulses once, only on the accepting cycle.

Source files
------------

// File: rtl/x86_length_decoder.sv
// rtl/x86_length_decoder.sv - byte-serial x86/x86-64 instruction length and field decoder
module x86_length_decoder #(
    parameter int WIN_BYTES = 16,
    parameter int MAX_LEN   = 15,
    parameter bit MODE64    = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   win_valid,
    input  logic [WIN_BYTES*8-1:0] win_bytes,
    output logic                   win_ready,
    output logic [3:0]             win_consume,
    output logic [1:0]             attr_map,
    output logic [7:0]             attr_opcode,
    output logic                   attr_opsize16,
    output logic                   attr_rex_w,
    input  logic                   attr_has_modrm,
    input  logic [3:0]             attr_imm_bytes,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             out_len,
    output logic [1:0]             out_error,
    output logic [7:0]             out_prefix,
    output logic                   out_rex_valid,
    output logic [3:0]             out_rex,
    output logic [1:0]             out_map,
    output logic [7:0]             out_opcode,
    output logic                   out_modrm_valid,
    output logic [7:0]             out_modrm,
    output logic                   out_sib_valid,
    output logic [7:0]             out_sib,
    output logic [2:0]             out_disp_bytes,
    output logic [31:0]            out_disp,
    output logic [3:0]             out_imm_bytes,
    output logic [63:0]            out_imm
);

    localparam int CW = $clog2(((WIN_BYTES > MAX_LEN) ? WIN_BYTES : MAX_LEN) + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PREFIX, S_ESC, S_ESC3, S_ATTR, S_MODRM, S_SIB, S_DISP, S_IMM, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cursor_q, cursor_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [1:0]    err_q, err_d;
    logic [7:0]    prefix_q, prefix_d;
    logic          rex_valid_q, rex_valid_d;
    logic [3:0]    rex_q, rex_d;
    logic [1:0]    map_q, map_d;
    logic [7:0]    opcode_q, opcode_d;
    logic          modrm_valid_q, modrm_valid_d;
    logic [7:0]    modrm_q, modrm_d;
    logic          sib_valid_q, sib_valid_d;
    logic [7:0]    sib_q, sib_d;
    logic [2:0]    disp_bytes_q, disp_bytes_d;
    logic [31:0]   disp_q, disp_d;
    logic [3:0]    imm_bytes_q, imm_bytes_d;
    logic [63:0]   imm_q, imm_d;

    logic [7:0]    cur_byte;
    logic          reads_byte;
    logic [2:0]    dsz;
    logic [63:0]   imm_acc;

    assign cur_byte = 8'(win_bytes >> {cursor_q, 3'b000});

    always_comb begin
        state_d       = state_q;
        cursor_d      = cursor_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        prefix_d      = prefix_q;
        rex_valid_d   = rex_valid_q;
        rex_d         = rex_q;
        map_d         = map_q;
        opcode_d      = opcode_q;
        modrm_valid_d = modrm_valid_q;
        modrm_d       = modrm_q;
        sib_valid_d   = sib_valid_q;
        sib_d         = sib_q;
        disp_bytes_d  = disp_bytes_q;
        disp_d        = disp_q;
        imm_bytes_d   = imm_bytes_q;
        imm_d         = imm_q;
        dsz           = 3'd0;
        imm_acc       = {cur_byte, imm_q[63:8]};
        reads_byte    = (state_q != S_IDLE) && (state_q != S_ATTR) && (state_q != S_DONE);

        if (reads_byte && cursor_q == CW'(MAX_LEN)) begin
            err_d   = 2'd1;
            state_d = S_DONE;
        end else if (reads_byte && cursor_q == CW'(WIN_BYTES)) begin
            err_d   = 2'd2;
            state_d = S_DONE;
        end else begin
            if (reads_byte) cursor_d = cursor_q + CW'(1);
            case (state_q)
                S_IDLE: begin
                    if (win_valid) begin
                        cursor_d      = '0;
                        cnt_d         = '0;
                        err_d         = '0;
                        prefix_d      = '0;
                        rex_valid_d   = 1'b0;
                        rex_d         = '0;
                        map_d         = '0;
                        opcode_d      = '0;
                        modrm_valid_d = 1'b0;
                        modrm_d       = '0;
                        sib_valid_d   = 1'b0;
                        sib_d         = '0;
                        disp_bytes_d  = '0;
                        disp_d        = '0;
                        imm_bytes_d   = '0;
                        imm_d         = '0;
                        state_d       = S_PREFIX;
                    end
                end
                S_PREFIX: begin
                    // A legacy prefix after REX demotes that REX, so clear it on every legacy byte
                    rex_valid_d = 1'b0;
                    rex_d       = '0;
                    case (cur_byte)
                        8'hF0: prefix_d[0] = 1'b1;
                        8'hF2: begin prefix_d[1] = 1'b1; prefix_d[2] = 1'b0; end
                        8'hF3: begin prefix_d[2] = 1'b1; prefix_d[1] = 1'b0; end
                        8'h66: prefix_d[3] = 1'b1;
                        8'h67: prefix_d[4] = 1'b1;
                        8'h26: prefix_d[7:5] = 3'd1;
                        8'h2E: prefix_d[7:5] = 3'd2;
                        8'h36: prefix_d[7:5] = 3'd3;
                        8'h3E: prefix_d[7:5] = 3'd4;
                        8'h64: prefix_d[7:5] = 3'd5;
                        8'h65: prefix_d[7:5] = 3'd6;
                        8'h0F: begin
                            rex_valid_d = rex_valid_q;
                            rex_d       = rex_q;
                            state_d     = S_ESC;
                        end
                        default: begin
                            if (MODE64 && cur_byte[7:4] == 4'h4) begin
                                rex_valid_d = 1'b1;
                                rex_d       = cur_byte[3:0];
                            end else begin
                                rex_valid_d = rex_valid_q;
                                rex_d       = rex_q;
                                map_d       = 2'd0;
                                opcode_d    = cur_byte;
                                state_d     = S_ATTR;
                            end
                        end
                    endcase
                end
                S_ESC: begin
                    if (cur_byte == 8'h38) begin
                        map_d   = 2'd2;
                        state_d = S_ESC3;
                    end else if (cur_byte == 8'h3A) begin
                        map_d   = 2'd3;
                        state_d = S_ESC3;
                    end else begin
                        map_d    = 2'd1;
                        opcode_d = cur_byte;
                        state_d  = S_ATTR;
                    end
                end
                S_ESC3: begin
                    opcode_d = cur_byte;
                    state_d  = S_ATTR;
                end
                S_ATTR: begin
                    imm_bytes_d = attr_imm_bytes;
                    if (attr_has_modrm) begin
                        state_d = S_MODRM;
                    end else if (attr_imm_bytes != 4'd0) begin
                        cnt_d   = attr_imm_bytes;
                        state_d = S_IMM;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_MODRM, S_SIB: begin
                    if (state_q == S_MODRM) begin
                        modrm_valid_d = 1'b1;
                        modrm_d       = cur_byte;
                        if (cur_byte[7:6] == 2'd1)                                dsz = 3'd1;
                        else if (cur_byte[7:6] == 2'd2)                           dsz = 3'd4;
                        else if (cur_byte[7:6] == 2'd0 && cur_byte[2:0] == 3'd5)  dsz = 3'd4;
                    end else begin
                        sib_valid_d = 1'b1;
                        sib_d       = cur_byte;
                        dsz         = disp_bytes_q;
                        if (modrm_q[7:6] == 2'd0 && cur_byte[2:0] == 3'd5) dsz = 3'd4;
                    end
                    disp_bytes_d = dsz;
                    if (state_q == S_MODRM && cur_byte[7:6] != 2'd3 && cur_byte[2:0] == 3'd4) begin
                        state_d = S_SIB;
                    end else if (dsz != 3'd0) begin
                        cnt_d   = {1'b0, dsz};
                        state_d = S_DISP;
                    end else if (imm_bytes_q != 4'd0) begin
                        cnt_d   = imm_bytes_q;
                        state_d = S_IMM;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_DISP: begin
                    if (disp_bytes_q == 3'd1) disp_d = {{24{cur_byte[7]}}, cur_byte};
                    else                      disp_d = {cur_byte, disp_q[31:8]};
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        if (imm_bytes_q != 4'd0) begin
                            cnt_d   = imm_bytes_q;
                            state_d = S_IMM;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_IMM: begin
                    // Bytes enter at the top; the final byte realigns the value down to bit 0
                    imm_d = imm_acc;
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        imm_d   = imm_acc >> {4'd8 - imm_bytes_q, 3'b000};
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            state_q       <= S_IDLE;
            cursor_q      <= '0;
            cnt_q         <= '0;
            err_q         <= '0;
            prefix_q      <= '0;
            rex_valid_q   <= 1'b0;
            rex_q         <= '0;
            map_q         <= '0;
            opcode_q      <= '0;
            modrm_valid_q <= 1'b0;
            modrm_q       <= '0;
            sib_valid_q   <= 1'b0;
            sib_q         <= '0;
            disp_bytes_q  <= '0;
            disp_q        <= '0;
            imm_bytes_q   <= '0;
            imm_q         <= '0;
        end else begin
            state_q       <= state_d;
            cursor_q      <= cursor_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            prefix_q      <= prefix_d;
            rex_valid_q   <= rex_valid_d;
            rex_q         <= rex_d;
            map_q         <= map_d;
            opcode_q      <= opcode_d;
            modrm_valid_q <= modrm_valid_d;
            modrm_q       <= modrm_d;
            sib_valid_q   <= sib_valid_d;
            sib_q         <= sib_d;
            disp_bytes_q  <= disp_bytes_d;
            disp_q        <= disp_d;
            imm_bytes_q   <= imm_bytes_d;
            imm_q         <= imm_d;
        end
    end

    assign out_valid       = (state_q == S_DONE);
    assign win_ready       = out_valid && out_ready;
    assign win_consume     = cursor_q[3:0];
    assign out_len         = cursor_q[3:0];
    assign out_error       = err_q;
    assign out_prefix      = prefix_q;
    assign out_rex_valid   = rex_valid_q;
    assign out_rex         = rex_q;
    assign out_map         = map_q;
    assign out_opcode      = opcode_q;
    assign out_modrm_valid = modrm_valid_q;
    assign out_modrm       = modrm_q;
    assign out_sib_valid   = sib_valid_q;
    assign out_sib         = sib_q;
    assign out_disp_bytes  = disp_bytes_q;
    assign out_disp        = disp_q;
    assign out_imm_bytes   = imm_bytes_q;
    assign out_imm         = imm_q;
    assign attr_map        = map_q;
    assign attr_opcode     = opcode_q;
    assign attr_opsize16   = prefix_q[3];
    assign attr_rex_w      = rex_valid_q & rex_q[3];

endmodule

// File: tb/tb_x86_length_decoder.sv
// tb/tb_x86_length_decoder.sv - directed self-checking bench for x86_length_decoder
module tb_x86_length_decoder;

    logic         clk = 1'b0;
    logic         reset, flush, win_valid, out_ready;
    logic [127:0] win_bytes;
    logic         win_ready, attr_opsize16, attr_rex_w, attr_has_modrm;
    logic [3:0]   win_consume, attr_imm_bytes, out_len, out_rex, out_imm_bytes;
    logic [1:0]   attr_map, out_error, out_map;
    logic [7:0]   attr_opcode, out_prefix, out_opcode, out_modrm, out_sib;
    logic         out_valid, out_rex_valid, out_modrm_valid, out_sib_valid;
    logic [2:0]   out_disp_bytes;
    logic [31:0]  out_disp;
    logic [63:0]  out_imm;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    logic [7:0] bq[$];

    x86_length_decoder #(.WIN_BYTES(16), .MAX_LEN(15), .MODE64(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush), .win_valid(win_valid), .win_bytes(win_bytes),
        .win_ready(win_ready), .win_consume(win_consume), .attr_map(attr_map),
        .attr_opcode(attr_opcode), .attr_opsize16(attr_opsize16), .attr_rex_w(attr_rex_w),
        .attr_has_modrm(attr_has_modrm), .attr_imm_bytes(attr_imm_bytes), .out_valid(out_valid),
        .out_ready(out_ready), .out_len(out_len), .out_error(out_error), .out_prefix(out_prefix),
        .out_rex_valid(out_rex_valid), .out_rex(out_rex), .out_map(out_map),
        .out_opcode(out_opcode), .out_modrm_valid(out_modrm_valid), .out_modrm(out_modrm),
        .out_sib_valid(out_sib_valid), .out_sib(out_sib), .out_disp_bytes(out_disp_bytes),
        .out_disp(out_disp), .out_imm_bytes(out_imm_bytes), .out_imm(out_imm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic has_modrm, input logic [3:0] imm);
        @(negedge clk);
        win_bytes = '0;
        foreach (bq[i]) win_bytes[8*i +: 8] = bq[i];
        attr_has_modrm = has_modrm;
        attr_imm_bytes = imm;
        out_ready      = 1'b0;
        win_valid      = 1'b1;
    endtask

    task automatic decode(input logic has_modrm, input logic [3:0] imm);
        present(has_modrm, imm);
        lat = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        chk("out_valid_timeout", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic accept(input logic [3:0] exp_len);
        out_ready = 1'b1;
        win_valid = 1'b0;
        #1;
        chk("win_ready_pulse", {63'd0, win_ready}, 64'd1);
        chk("win_consume", {60'd0, win_consume}, {60'd0, exp_len});
        @(negedge clk);
        chk("out_valid_drop", {63'd0, out_valid}, 64'd0);
        chk("win_ready_drop", {63'd0, win_ready}, 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; win_valid = 1'b0; out_ready = 1'b0;
        win_bytes = '0; attr_has_modrm = 1'b0; attr_imm_bytes = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_win_ready", {63'd0, win_ready}, 64'd0);
        chk("rst_len", {60'd0, out_len}, 64'd0);
        chk("rst_opcode", {56'd0, out_opcode}, 64'd0);
        chk("rst_imm", out_imm, 64'd0);
        reset = 1'b1;

        bq = '{8'h90};
        decode(1'b0, 4'd0);
        chk("nop_latency", lat, 64'd3);
        chk("nop_len", {60'd0, out_len}, 64'd1);
        chk("nop_map", {62'd0, out_map}, 64'd0);
        chk("nop_opcode", {56'd0, out_opcode}, 64'h90);
        chk("nop_modrm_valid", {63'd0, out_modrm_valid}, 64'd0);
        chk("nop_error", {62'd0, out_error}, 64'd0);
        accept(4'd1);

        bq = '{8'h48, 8'h89, 8'hE5};
        decode(1'b1, 4'd0);
        chk("mov_latency", lat, 64'd5);
        chk("mov_rex_valid", {63'd0, out_rex_valid}, 64'd1);
        chk("mov_rex", {60'd0, out_rex}, 64'h8);
        chk("mov_rex_w", {63'd0, attr_rex_w}, 64'd1);
        chk("mov_modrm", {56'd0, out_modrm}, 64'hE5);
        chk("mov_sib_valid", {63'd0, out_sib_valid}, 64'd0);
        chk("mov_disp_bytes", {61'd0, out_disp_bytes}, 64'd0);
        chk("mov_len", {60'd0, out_len}, 64'd3);
        accept(4'd3);

        bq = '{8'h66, 8'h0F, 8'h38, 8'h00, 8'hC1};
        decode(1'b1, 4'd0);
        chk("pshufb_prefix", {56'd0, out_prefix}, 64'h08);
        chk("pshufb_map", {62'd0, out_map}, 64'd2);
        chk("pshufb_opcode", {56'd0, out_opcode}, 64'h00);
        chk("pshufb_modrm", {56'd0, out_modrm}, 64'hC1);
        chk("pshufb_len", {60'd0, out_len}, 64'd5);
        accept(4'd5);

        bq = '{8'h8B, 8'h44, 8'h24, 8'h08};
        decode(1'b1, 4'd0);
        chk("sib_valid", {63'd0, out_sib_valid}, 64'd1);
        chk("sib_byte", {56'd0, out_sib}, 64'h24);
        chk("sib_disp", {32'd0, out_disp}, 64'h8);
        chk("sib_disp_bytes", {61'd0, out_disp_bytes}, 64'd1);
        chk("sib_len", {60'd0, out_len}, 64'd4);
        accept(4'd4);

        bq = '{8'h8B, 8'h45, 8'hF8};
        decode(1'b1, 4'd0);
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_win_ready", {63'd0, win_ready}, 64'd0);
            chk("stall_disp", {32'd0, out_disp}, 64'hFFFFFFF8);
            chk("stall_disp_bytes", {61'd0, out_disp_bytes}, 64'd1);
            chk("stall_len", {60'd0, out_len}, 64'd3);
            @(negedge clk);
        end
        accept(4'd3);

        bq = '{8'h48, 8'hC7, 8'h05, 8'h10, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        decode(1'b1, 4'd4);
        chk("movimm_modrm", {56'd0, out_modrm}, 64'h05);
        chk("movimm_disp", {32'd0, out_disp}, 64'h10);
        chk("movimm_disp_bytes", {61'd0, out_disp_bytes}, 64'd4);
        chk("movimm_imm", out_imm, 64'h00000000FFFFFFFF);
        chk("movimm_imm_bytes", {60'd0, out_imm_bytes}, 64'd4);
        chk("movimm_len", {60'd0, out_len}, 64'd11);
        accept(4'd11);

        bq = '{8'h83, 8'hC0, 8'h85};
        decode(1'b1, 4'd1);
        chk("add_imm", out_imm, 64'h85);
        chk("add_disp_bytes", {61'd0, out_disp_bytes}, 64'd0);
        chk("add_len", {60'd0, out_len}, 64'd3);
        accept(4'd3);

        bq = {};
        for (int i = 0; i < 16; i++) bq.push_back(8'hF0);
        decode(1'b0, 4'd0);
        chk("long_error", {62'd0, out_error}, 64'd1);
        chk("long_len", {60'd0, out_len}, 64'd15);
        chk("long_prefix", {56'd0, out_prefix}, 64'h01);
        accept(4'd15);

        bq = '{8'h40, 8'h66, 8'h90};
        decode(1'b0, 4'd0);
        chk("rexdrop_rex_valid", {63'd0, out_rex_valid}, 64'd0);
        chk("rexdrop_prefix", {56'd0, out_prefix}, 64'h08);
        chk("rexdrop_opcode", {56'd0, out_opcode}, 64'h90);
        chk("rexdrop_len", {60'd0, out_len}, 64'd3);
        accept(4'd3);

        bq = '{8'h8B, 8'h85, 8'h11, 8'h22, 8'h33, 8'h44};
        present(1'b1, 4'd0);
        repeat (4) @(negedge clk);
        flush     = 1'b1;
        win_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
            chk("flush_win_ready", {63'd0, win_ready}, 64'd0);
            @(negedge clk);
        end

        bq = '{8'h90};
        decode(1'b0, 4'd0);
        chk("postflush_latency", lat, 64'd3);
        chk("postflush_len", {60'd0, out_len}, 64'd1);
        chk("postflush_error", {62'd0, out_error}, 64'd0);
        chk("postflush_disp", {32'd0, out_disp}, 64'd0);
        chk("postflush_modrm_valid", {63'd0, out_modrm_valid}, 64'd0);
        accept(4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
